core_data_axi_master: RTL and testbench
=======================================

Name: core_data_axi_master

Overview:
- Bridge that turns core data-port requests (req/gnt/rvalid handshake, CORE_DATA_INF signalling) into single-beat AXI4 master transactions.
- It is the initiating counterpart to the AXI4 slave port of core_data_top: it lets the core reach off-tile peripherals and memory through the crossbar.
- One transaction is outstanding at a time.
- Write data is sent on AW and W concurrently. The B or R response comes back to the core as a one-cycle rvalid pulse.

Parameters:
- AxiAddrWidth, 32, AXI address width; also the core address width.
- AxiDataWidth, 32, AXI and core data width. Must be 32.
- AxiID_WIDTH, 8, AXI ID width.
- AxiID, 0, constant ID driven on aw_id and ar_id.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  core request
- data_addr_i  in  AxiAddrWidth  byte address
- data_we_i  in  1  1=write, 0=read
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  request accepted
- data_rvalid_o  out  1  response pulse
- data_rdata_o  out  32  read data
- data_err_o  out  1  bus error, valid with rvalid
- aw_id_o/aw_addr_o/aw_len_o/aw_size_o/aw_burst_o/aw_prot_o  out  ID/Addr/8/3/2/3  AW payload
- aw_valid_o  out  1 ; aw_ready_i  in  1
- w_data_o  out  32 ; w_strb_o  out  4 ; w_last_o  out  1 ; w_valid_o  out  1 ; w_ready_i  in  1
- b_resp_i  in  2 ; b_valid_i  in  1 ; b_ready_o  out  1
- ar_id_o/ar_addr_o/ar_len_o/ar_size_o/ar_burst_o/ar_prot_o  out  ID/Addr/8/3/2/3  AR payload
- ar_valid_o  out  1 ; ar_ready_i  in  1
- r_data_i  in  32 ; r_resp_i  in  2 ; r_last_i  in  1 ; r_valid_i  in  1 ; r_ready_o  out  1
- All other AXI fields (lock, cache, qos, region, atop, user) are tied to 0 by the instantiating wrapper.

Behaviour:
- Constant AXI fields:
  - len=0, size=3'd2, burst=INCR (2'b01), prot=0, w_last=1.
  - addr is data_addr_i captured unmodified; w_strb=captured be.
- States: IDLE, WRITE (AW/W in flight), WRITE_RESP, READ_ADDR, READ_DATA.
- Grant:
  - data_gnt_o = data_req_i & (state==IDLE), combinational.
  - On the gnt edge, addr, we, be and wdata are registered. The next state is WRITE if we=1, otherwise READ_ADDR.
- WRITE:
  - aw_valid_o and w_valid_o both assert from the cycle after gnt.
  - Each channel drops independently after its own handshake, tracked by aw_done/w_done flags. Either order and a same-cycle handshake are legal.
  - When both are done, go to WRITE_RESP.
  - Payload stays stable while valid is high. Valid never drops before its ready.
- WRITE_RESP: b_ready_o=1. On b_valid_i, go to IDLE and register rvalid=1, err=(b_resp_i!=2'b00), rdata=0.
- READ_ADDR: ar_valid_o=1 until ar_ready_i, then go to READ_DATA.
- READ_DATA: r_ready_o=1. On r_valid_i, go to IDLE and register rvalid=1, rdata=r_data_i, err=(r_resp_i!=2'b00).
- Response pulse: data_rvalid_o is high for exactly one cycle. data_rdata_o and data_err_o hold their values until the next response.
- Throughput: a new gnt is allowed in the same cycle rvalid is high, since the FSM is already IDLE. Minimum latency from gnt to rvalid is 3 cycles with zero-wait slaves.
- AXI ready inputs arriving outside their owning state are ignored.
- Reset, including mid-transaction:
  - All states return to IDLE and the done flags clear.
  - All valid/ready outputs, data_gnt_o, data_rvalid_o, data_err_o and data_rdata_o go to 0.
  - The aborted transaction produces no rvalid.
- The IDs of the B and R responses are not checked; the single outstanding transaction makes that unnecessary.

Test Plan:
- Write 0x3000_0000 <- 0xbeafbeef, be=4'hF, slave ready immediately:
  - AW and W are both presented the cycle after gnt, with strb=4'hF, last=1, size=2.
  - B OKAY gives one rvalid pulse with err=0, 3 cycles after gnt.
- Read 0x3000_0000, slave returns 0xbeafbeef after 4 wait cycles on R: ar_valid is held until ready, then rvalid with rdata=0xbeafbeef and err=0.
- Write with w_ready delayed 3 cycles after aw_ready:
  - aw_valid drops after its handshake and w_valid stays high.
  - Exactly one AW and one W beat appear, and b_ready rises only after both handshakes.
- Back-to-back: write 0x3000_0004=0x1, then a read of 0x3000_0004 requested in the rvalid cycle:
  - The read is granted in that same cycle.
  - It returns 0x1 (AR issued only after B).
- Error: slave returns SLVERR (2'b10) on B, then DECERR (2'b11) on R: each gives data_err_o=1 on its rvalid pulse.
- Reset mid-op: assert rst_ni=0 while aw_valid is pending:
  - All outputs go to 0 immediately, with no rvalid.
  - After release, a read of 0x3000_0000 completes normally.

Source files
------------

// File: rtl/core_data_axi_master_if.sv
// AXI4 single-beat channel bundle between the core data bridge and the interconnect.
// Only the fields the bridge drives or consumes are carried; the rest are tied off outside.
interface core_data_axi_master_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 8
);
  logic [IdWidth-1:0]     aw_id;
  logic [AddrWidth-1:0]   aw_addr;
  logic [7:0]             aw_len;
  logic [2:0]             aw_size;
  logic [1:0]             aw_burst;
  logic [2:0]             aw_prot;
  logic                   aw_valid;
  logic                   aw_ready;

  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_last;
  logic                   w_valid;
  logic                   w_ready;

  logic [1:0]             b_resp;
  logic                   b_valid;
  logic                   b_ready;

  logic [IdWidth-1:0]     ar_id;
  logic [AddrWidth-1:0]   ar_addr;
  logic [7:0]             ar_len;
  logic [2:0]             ar_size;
  logic [1:0]             ar_burst;
  logic [2:0]             ar_prot;
  logic                   ar_valid;
  logic                   ar_ready;

  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_last;
  logic                   r_valid;
  logic                   r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/core_data_axi_master.sv
// Bridges core data-port requests (req/gnt/rvalid) onto single-beat AXI4 master transactions,
// one outstanding at a time; B or R comes back to the core as a one-cycle rvalid pulse.
module core_data_axi_master #(
  parameter int unsigned            AxiAddrWidth = 32,
  parameter int unsigned            AxiDataWidth = 32,
  parameter int unsigned            AxiID_WIDTH  = 8,
  parameter logic [AxiID_WIDTH-1:0] AxiID        = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    data_req_i,
  input  logic [AxiAddrWidth-1:0] data_addr_i,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  input  logic [AxiDataWidth-1:0] data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [AxiDataWidth-1:0] data_rdata_o,
  output logic                    data_err_o,

  core_data_axi_master_if.master  axi
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWriteResp,
    StReadAddr,
    StReadData
  } state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [AxiDataWidth-1:0] wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    aw_valid_q, aw_valid_d;
  logic                    w_valid_q, w_valid_d;
  logic                    b_ready_q, b_ready_d;
  logic                    ar_valid_q, ar_valid_d;
  logic                    r_ready_q, r_ready_d;
  logic                    rvalid_q, rvalid_d;
  logic [AxiDataWidth-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic aw_hs, w_hs;
  logic unused_r_last;

  // Gated with reset so the core never sees a grant while the bridge is held in reset.
  assign data_gnt_o    = data_req_i & (state_q == StIdle) & rst_ni;
  assign unused_r_last = axi.r_last;

  // Handshakes only count while the owning state is active.
  assign aw_hs = (state_q == StWrite) & aw_valid_q & axi.aw_ready;
  assign w_hs  = (state_q == StWrite) & w_valid_q  & axi.w_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (data_gnt_o) begin
          addr_d  = data_addr_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          if (data_we_i) begin
            state_d    = StWrite;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = StReadAddr;
            ar_valid_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = StWriteResp;
          b_ready_d = 1'b1;
        end
      end
      StWriteResp: begin
        if (axi.b_valid) begin
          state_d   = StIdle;
          b_ready_d = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          err_d     = (axi.b_resp != 2'b00);
        end
      end
      StReadAddr: begin
        if (axi.ar_ready) begin
          state_d    = StReadData;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      StReadData: begin
        if (axi.r_valid) begin
          state_d   = StIdle;
          r_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = axi.r_data;
          err_d     = (axi.r_resp != 2'b00);
        end
      end
      default: begin
        state_d    = StIdle;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        b_ready_d  = 1'b0;
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  assign axi.aw_id    = AxiID;
  assign axi.aw_addr  = addr_q;
  assign axi.aw_len   = 8'd0;
  assign axi.aw_size  = 3'd2;
  assign axi.aw_burst = 2'b01;
  assign axi.aw_prot  = 3'b000;
  assign axi.aw_valid = aw_valid_q;

  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = be_q;
  assign axi.w_last   = 1'b1;
  assign axi.w_valid  = w_valid_q;

  assign axi.b_ready  = b_ready_q;

  assign axi.ar_id    = AxiID;
  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = 8'd0;
  assign axi.ar_size  = 3'd2;
  assign axi.ar_burst = 2'b01;
  assign axi.ar_prot  = 3'b000;
  assign axi.ar_valid = ar_valid_q;

  assign axi.r_ready  = r_ready_q;

endmodule

// File: tb/tb_core_data_axi_master.sv
// Scoreboard bench for core_data_axi_master: a configurable AXI slave model with a small
// memory, a core-side driver that queues expected responses, and an rvalid monitor.
module tb_core_data_axi_master;

  logic        clk;
  logic        rst_n;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  core_data_axi_master_if axi_bus ();

  core_data_axi_master dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (data_req),
    .data_addr_i   (data_addr),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_wdata_i  (data_wdata),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .axi           (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [logic [31:0]];

  // Slave configuration, set by the stimulus before each request.
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] cfg_addr = '0, cfg_wdata = '0;
  logic [3:0]  cfg_strb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({data_gnt, data_rvalid, data_err, data_rdata, axi_bus.aw_valid, axi_bus.w_valid,
                axi_bus.b_ready, axi_bus.ar_valid, axi_bus.r_ready});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request from the current phase; pushes the expected response on grant.
  task automatic core_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                          input int elat, output int waits);
    exp_t e;
    waits      = 0;
    cfg_addr   = addr;
    cfg_wdata  = wd;
    cfg_strb   = be;
    data_req   = 1'b1;
    data_addr  = addr;
    data_we    = we;
    data_be    = be;
    data_wdata = wd;
    forever begin
      @(negedge clk);
      if (data_gnt) break;
      waits++;
      if (waits > 50) break;
    end
    if (!data_gnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got gnt=0 expected gnt=1 addr=0x%0h", addr);
    end else begin
      e.rdata = erd;
      e.err   = eerr;
      e.gcyc  = cyc;
      e.lat   = elat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL response_timeout: got pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // AXI slave model: ready/response decisions made on the falling edge.
  initial begin : slave
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [31:0] wa = '0, wd = '0, ra = '0, cur;
    logic [3:0]  ws = '0;
    axi_bus.aw_ready = 1'b0;
    axi_bus.w_ready  = 1'b0;
    axi_bus.b_valid  = 1'b0;
    axi_bus.b_resp   = 2'b00;
    axi_bus.ar_ready = 1'b0;
    axi_bus.r_valid  = 1'b0;
    axi_bus.r_data   = '0;
    axi_bus.r_resp   = 2'b00;
    axi_bus.r_last   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        axi_bus.aw_ready = 1'b0;
        axi_bus.w_ready  = 1'b0;
        axi_bus.b_valid  = 1'b0;
        axi_bus.ar_ready = 1'b0;
        axi_bus.r_valid  = 1'b0;
        continue;
      end
      if (axi_bus.aw_valid && aw_wait >= aw_delay) begin
        axi_bus.aw_ready = 1'b1;
        aw_cnt++;
        aw_wait = 0;
        wa = axi_bus.aw_addr;
        check("aw_payload", 64'({axi_bus.aw_id, axi_bus.aw_addr, axi_bus.aw_len, axi_bus.aw_size,
                                 axi_bus.aw_burst, axi_bus.aw_prot}),
              64'({8'h00, cfg_addr, 8'h00, 3'd2, 2'b01, 3'b000}));
      end else begin
        axi_bus.aw_ready = 1'b0;
        aw_wait = axi_bus.aw_valid ? aw_wait + 1 : 0;
      end
      if (axi_bus.w_valid && w_wait >= w_delay) begin
        axi_bus.w_ready = 1'b1;
        w_cnt++;
        w_wait = 0;
        wd = axi_bus.w_data;
        ws = axi_bus.w_strb;
        check("w_payload", 64'({axi_bus.w_data, axi_bus.w_strb, axi_bus.w_last}),
              64'({cfg_wdata, cfg_strb, 1'b1}));
      end else begin
        axi_bus.w_ready = 1'b0;
        w_wait = axi_bus.w_valid ? w_wait + 1 : 0;
      end
      if (axi_bus.b_valid) begin
        axi_bus.b_valid = 1'b0;
      end else if (axi_bus.b_ready) begin
        if (b_wait == 0) begin
          check("aw_beats_before_bready", 64'(aw_cnt), 64'd1);
          check("w_beats_before_bready", 64'(w_cnt), 64'd1);
        end
        if (b_wait >= b_delay) begin
          cur = mem.exists(wa) ? mem[wa] : 32'h0;
          for (int i = 0; i < 4; i++) if (ws[i]) cur[8*i +: 8] = wd[8*i +: 8];
          mem[wa] = cur;
          axi_bus.b_valid = 1'b1;
          axi_bus.b_resp  = b_resp_cfg;
          aw_cnt = 0;
          w_cnt  = 0;
          b_wait = 0;
        end else begin
          b_wait++;
        end
      end
      if (axi_bus.ar_valid && ar_wait >= ar_delay) begin
        axi_bus.ar_ready = 1'b1;
        ar_cnt++;
        ar_wait = 0;
        ra = axi_bus.ar_addr;
        check("ar_payload", 64'({axi_bus.ar_id, axi_bus.ar_addr, axi_bus.ar_len, axi_bus.ar_size,
                                 axi_bus.ar_burst, axi_bus.ar_prot}),
              64'({8'h00, cfg_addr, 8'h00, 3'd2, 2'b01, 3'b000}));
      end else begin
        axi_bus.ar_ready = 1'b0;
        ar_wait = axi_bus.ar_valid ? ar_wait + 1 : 0;
      end
      if (axi_bus.r_valid) begin
        axi_bus.r_valid = 1'b0;
      end else if (axi_bus.r_ready) begin
        if (r_wait == 0) check("ar_beats_before_rready", 64'(ar_cnt), 64'd1);
        if (r_wait >= r_delay) begin
          axi_bus.r_valid = 1'b1;
          axi_bus.r_data  = mem.exists(ra) ? mem[ra] : 32'h0;
          axi_bus.r_resp  = r_resp_cfg;
          axi_bus.r_last  = 1'b1;
          ar_cnt = 0;
          r_wait = 0;
        end else begin
          r_wait++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every rvalid pulse.
  initial begin : monitor
    logic        prev_rv = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rv = 1'b0;
        continue;
      end
      if (data_rvalid) begin
        check("rvalid_single_cycle", 64'(prev_rv), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got rdata=0x%0h err=%0b expected no response",
                   data_rdata, data_err);
        end else begin
          e = exp_q.pop_front();
          check("rdata", 64'(data_rdata), 64'(e.rdata));
          check("err", 64'(data_err), 64'(e.err));
          if (e.lat >= 0) check("gnt_to_rvalid_latency", 64'(cyc - e.gcyc), 64'(e.lat));
        end
        last_rdata = data_rdata;
        last_err   = data_err;
      end else if (prev_rv) begin
        check("rdata_err_hold", 64'({data_err, data_rdata}), 64'({last_err, last_rdata}));
      end
      prev_rv = data_rvalid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    data_req   = 1'b0;
    data_addr  = '0;
    data_we    = 1'b0;
    data_be    = '0;
    data_wdata = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    step();

    // Zero-wait write; both AW and W presented the cycle after grant.
    core_req(32'h3000_0000, 1'b1, 4'hF, 32'hbeafbeef, 32'h0, 1'b0, 3, w);
    check("aw_w_valid_after_gnt", 64'({axi_bus.aw_valid, axi_bus.w_valid}), 64'b11);
    wait_done();

    // Read with AR held two cycles and four R wait cycles.
    ar_delay = 2;
    r_delay  = 4;
    step();
    core_req(32'h3000_0000, 1'b0, 4'hF, 32'h0, 32'hbeafbeef, 1'b0, -1, w);
    wait_done();
    ar_delay = 0;
    r_delay  = 0;

    // W accepted three cycles after AW: AW must drop, W must stay up, no B ready yet.
    w_delay = 3;
    step();
    core_req(32'h3000_0008, 1'b1, 4'hF, 32'ha5a5_0f0f, 32'h0, 1'b0, -1, w);
    @(negedge clk);
    @(negedge clk);
    check("aw_dropped_w_held", 64'({axi_bus.aw_valid, axi_bus.w_valid, axi_bus.b_ready}),
          64'b010);
    wait_done();
    w_delay = 0;
    step();
    core_req(32'h3000_0008, 1'b0, 4'hF, 32'h0, 32'ha5a5_0f0f, 1'b0, 3, w);
    wait_done();

    // Back-to-back: read requested in the write's rvalid cycle.
    step();
    core_req(32'h3000_0004, 1'b1, 4'hF, 32'h0000_0001, 32'h0, 1'b0, 3, w);
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_rvalid) break;
    end
    core_req(32'h3000_0004, 1'b0, 4'hF, 32'h0, 32'h0000_0001, 1'b0, 3, w);
    check("b2b_gnt_in_rvalid_cycle", 64'(w), 64'd0);
    wait_done();

    // SLVERR on B, then DECERR on R.
    b_resp_cfg = 2'b10;
    step();
    core_req(32'h3000_000c, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b1, 3, w);
    wait_done();
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11;
    step();
    core_req(32'h3000_000c, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b1, 3, w);
    wait_done();
    r_resp_cfg = 2'b00;

    // Partial byte enables reach w_strb.
    step();
    core_req(32'h3000_0010, 1'b1, 4'h3, 32'haabb_ccdd, 32'h0, 1'b0, 3, w);
    wait_done();
    step();
    core_req(32'h3000_0010, 1'b0, 4'hF, 32'h0, 32'h0000_ccdd, 1'b0, 3, w);
    wait_done();

    // Reset while AW/W are stalled.
    aw_delay = 1000;
    w_delay  = 1000;
    step();
    core_req(32'h3000_0014, 1'b1, 4'hF, 32'hdead_beef, 32'h0, 1'b0, -1, w);
    @(negedge clk);
    check("aw_pending_before_reset", 64'(axi_bus.aw_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("outputs_in_reset", outs(), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("outputs_held_in_reset", outs(), 64'd0);
    aw_delay = 0;
    w_delay  = 0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    check("outputs_after_release", outs(), 64'd0);
    step();
    core_req(32'h3000_0000, 1'b0, 4'hF, 32'h0, 32'hbeafbeef, 1'b0, 3, w);
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
